// File: rtl/data_bus_router.sv
// Data-side address router for the CV32E40P: decodes each request to one slave,
// allows one outstanding transaction, answers writes locally and reports unmapped or timed-out accesses.
module data_bus_router #(
  parameter int unsigned NUM_SLAVES = 3,
  // slot i lives at [32*i +: 32]; slot 0 (data memory) is the rightmost word
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {32'h0030_0000, 32'h0020_0000, 32'h0010_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_E000},
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     m_req_i,
  output logic                     m_gnt_o,
  output logic                     m_rvalid_o,
  input  logic [31:0]              m_addr_i,
  input  logic                     m_we_i,
  input  logic [3:0]               m_be_i,
  input  logic [31:0]              m_wdata_i,
  output logic [31:0]              m_rdata_o,
  output logic [NUM_SLAVES-1:0]    s_req_o,
  input  logic [NUM_SLAVES-1:0]    s_gnt_i,
  input  logic [NUM_SLAVES-1:0]    s_rvalid_i,
  output logic [31:0]              s_addr_o,
  output logic                     s_we_o,
  output logic [3:0]               s_be_o,
  output logic [31:0]              s_wdata_o,
  input  logic [NUM_SLAVES*32-1:0] s_rdata_i,
  output logic                     bus_err_o,
  output logic [31:0]              err_addr_o,
  input  logic                     err_clr_i
);

  localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_GNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_RSP_LAST = CW'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RD_WAIT    = 2'd1,
    ST_LOCAL_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            err_q, err_d;
  logic            bus_err_q, bus_err_d;
  logic [31:0]     err_addr_q, err_addr_d;

  logic [NUM_SLAVES-1:0] hit_vec_s;
  logic                  hit_any_s;
  logic [SW-1:0]         dec_sel_s;
  logic [31:0]           rdata_sel_s;
  logic                  capture_s;
  logic [NUM_SLAVES-1:0] s_req_s;
  logic                  m_gnt_s;
  logic                  m_rvalid_s;
  logic [31:0]           m_rdata_s;

  // Address decode: lowest-index hit wins; read-data mux by latched slot
  always_comb begin
    hit_vec_s   = '0;
    dec_sel_s   = '0;
    rdata_sel_s = 32'h0000_0000;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit_vec_s[i] = ((m_addr_i & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]);
    end
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      dec_sel_s = hit_vec_s[i] ? SW'(i) : dec_sel_s;
    end
    for (int i = 0; i < NUM_SLAVES; i++) begin
      rdata_sel_s = (sel_q == SW'(i)) ? s_rdata_i[32*i +: 32] : rdata_sel_s;
    end
    hit_any_s = |hit_vec_s;
  end

  // Next-state, handshake outputs and error capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    err_d      = err_q;
    capture_s  = 1'b0;
    s_req_s    = '0;
    m_gnt_s    = 1'b0;
    m_rvalid_s = 1'b0;
    m_rdata_s  = 32'h0000_0000;
    case (state_q)
      ST_IDLE: begin
        if (m_req_i) begin
          if (!hit_any_s || (cnt_q == CNT_GNT_LAST)) begin
            // unmapped or starved: accept locally and answer with an error
            m_gnt_s   = 1'b1;
            err_d     = 1'b1;
            capture_s = 1'b1;
            cnt_d     = '0;
            state_d   = ST_LOCAL_RESP;
          end else begin
            s_req_s[dec_sel_s] = 1'b1;
            m_gnt_s            = s_gnt_i[dec_sel_s];
            if (s_gnt_i[dec_sel_s]) begin
              sel_d   = dec_sel_s;
              err_d   = 1'b0;
              cnt_d   = '0;
              state_d = m_we_i ? ST_LOCAL_RESP : ST_RD_WAIT;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end else begin
          cnt_d = '0;
        end
      end
      ST_RD_WAIT: begin
        if (s_rvalid_i[sel_q]) begin
          m_rvalid_s = 1'b1;
          m_rdata_s  = rdata_sel_s;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end else if (cnt_q == CNT_RSP_LAST) begin
          err_d     = 1'b1;
          capture_s = 1'b1;
          cnt_d     = '0;
          state_d   = ST_LOCAL_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LOCAL_RESP: begin
        m_rvalid_s = 1'b1;
        m_rdata_s  = err_q ? ERR_RDATA : 32'h0000_0000;
        cnt_d      = '0;
        state_d    = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    bus_err_d  = bus_err_q;
    err_addr_d = err_addr_q;
    if (err_clr_i) begin
      bus_err_d  = 1'b0;
      err_addr_d = 32'h0000_0000;
    end else if (capture_s) begin
      bus_err_d  = 1'b1;
      err_addr_d = bus_err_q ? err_addr_q : m_addr_i;
    end else begin
      bus_err_d  = bus_err_q;
      err_addr_d = err_addr_q;
    end
  end

  // State, counter and error registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      err_q      <= 1'b0;
      bus_err_q  <= 1'b0;
      err_addr_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // IDLE decode is combinational on core inputs, so force handshakes quiet while in reset
  assign s_req_o    = s_req_s & {NUM_SLAVES{rst_ni}};
  assign m_gnt_o    = m_gnt_s & rst_ni;
  assign m_rvalid_o = m_rvalid_s & rst_ni;
  assign m_rdata_o  = m_rdata_s & {32{rst_ni}};

  assign s_addr_o   = m_addr_i;
  assign s_we_o     = m_we_i;
  assign s_be_o     = m_be_i;
  assign s_wdata_o  = m_wdata_i;
  assign bus_err_o  = bus_err_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_data_bus_router.sv
// Bench for data_bus_router: table of directed transactions, randomized transactions
// against a latency/error model, and an asynchronous reset sequence.
module tb_data_bus_router;
  localparam int NS = 3;
  localparam int T  = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni, m_req_i, m_we_i, err_clr_i;
  logic [31:0]     m_addr_i, m_wdata_i;
  logic [3:0]      m_be_i;
  logic [NS-1:0]   s_gnt_i, s_rvalid_i;
  logic [NS*32-1:0] s_rdata_i;
  logic            m_gnt_o, m_rvalid_o, s_we_o, bus_err_o;
  logic [31:0]     m_rdata_o, s_addr_o, s_wdata_o, err_addr_o;
  logic [3:0]      s_be_o;
  logic [NS-1:0]   s_req_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit         be_m;
  logic [31:0] ea_m;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          gnt_dly;
    int          rv_dly;
    logic [31:0] rdata;
    bit          spur;
    bit          clr_before;
    bit          clr_at_gnt;
    int          exp_slave;
    int          exp_gnt;
    int          exp_rsp;
    logic [31:0] exp_rdata;
    logic        exp_bus_err;
    logic [31:0] exp_err_addr;
  } vec_t;

  data_bus_router dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
    .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
    .m_wdata_i(m_wdata_i), .m_rdata_o(m_rdata_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
    .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i),
    .bus_err_o(bus_err_o), .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    if ((a & 32'hFFFF_E000) == 32'h0010_0000) return 0;
    else if ((a & 32'hFFFF_0000) == 32'h0020_0000) return 1;
    else if ((a & 32'hFFFF_0000) == 32'h0030_0000) return 2;
    else return -1;
  endfunction

  // Latency/error rules: unmapped -> grant now; no grant within T cycles -> grant at T;
  // writes answer one cycle after grant; reads time out T cycles after grant.
  task automatic predict(inout vec_t v);
    bit err;
    err = 1'b0;
    v.exp_slave = ref_decode(v.addr);
    if (v.clr_before) begin be_m = 1'b0; ea_m = 32'h0; end
    if (v.exp_slave < 0) begin
      v.exp_gnt = 1; v.exp_rsp = 2; err = 1'b1;
    end else if (v.gnt_dly >= T - 1) begin
      v.exp_gnt = T; v.exp_rsp = T + 1; err = 1'b1;
    end else begin
      v.exp_gnt = v.gnt_dly + 1;
      if (v.we) v.exp_rsp = v.exp_gnt + 1;
      else if (v.rv_dly <= T - 1) v.exp_rsp = v.exp_gnt + v.rv_dly;
      else begin v.exp_rsp = v.exp_gnt + T; err = 1'b1; end
    end
    v.exp_rdata = err ? 32'hDEAD_BEEF : (v.we ? 32'h0 : v.rdata);
    if (err) begin
      if (!be_m) ea_m = v.addr;
      be_m = 1'b1;
    end
    v.exp_bus_err  = be_m;
    v.exp_err_addr = ea_m;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int gobs;
    bit sl_gnt;
    int other;
    logic [NS-1:0] exp_req;
    if (v.clr_before) begin
      err_clr_i = 1'b1;
      @(posedge clk_i); #1;
      err_clr_i = 1'b0;
      chk({tag, " clr"}, {bus_err_o, err_addr_o}, {1'b0, 32'h0});
    end
    gobs = 0; sl_gnt = 1'b0;
    other = (v.exp_slave + 1) % NS;
    m_addr_i = v.addr; m_we_i = v.we; m_be_i = v.be; m_wdata_i = v.wdata;
    for (int c = 1; c <= v.exp_rsp; c++) begin
      m_req_i = (gobs == 0);
      s_gnt_i = '0; s_rvalid_i = '0;
      for (int k = 0; k < NS; k++) s_rdata_i[32*k +: 32] = $urandom;
      if (v.exp_slave >= 0) begin
        if (gobs == 0 && c == v.gnt_dly + 1) s_gnt_i[v.exp_slave] = 1'b1;
        if (sl_gnt && !v.we && c - gobs == v.rv_dly) begin
          s_rvalid_i[v.exp_slave] = 1'b1;
          s_rdata_i[32*v.exp_slave +: 32] = v.rdata;
        end
        if (v.spur && sl_gnt && c == gobs + 1) begin
          s_rvalid_i[other] = 1'b1;
          s_rdata_i[32*other +: 32] = 32'h1111_1111;
        end
      end
      err_clr_i = v.clr_at_gnt && (c == v.exp_gnt);
      @(negedge clk_i);
      exp_req = (v.exp_slave >= 0 && c <= v.exp_gnt && c <= T - 1) ? (NS'(1) << v.exp_slave) : '0;
      chk($sformatf("%s c%0d gnt/rvalid/req/rdata", tag, c),
          {m_gnt_o, m_rvalid_o, s_req_o, m_rdata_o},
          {(c == v.exp_gnt), (c == v.exp_rsp), exp_req, ((c == v.exp_rsp) ? v.exp_rdata : 32'h0)});
      if (c == 1)
        chk({tag, " passthrough"}, {s_addr_o, s_we_o, s_be_o, s_wdata_o}, {v.addr, v.we, v.be, v.wdata});
      if (m_gnt_o && gobs == 0) begin
        gobs = c;
        sl_gnt = (v.exp_slave >= 0) && s_gnt_i[v.exp_slave] && s_req_o[v.exp_slave];
      end
      if (c == v.exp_rsp)
        chk({tag, " errregs"}, {bus_err_o, err_addr_o}, {v.exp_bus_err, v.exp_err_addr});
      else begin
        @(posedge clk_i); #1;
      end
    end
    @(posedge clk_i); #1;
    m_req_i = 1'b0; s_gnt_i = '0; s_rvalid_i = '0; err_clr_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [14];
    vec_t rv;
    int   r;
    //          addr          we    be     wdata         gd  rv  rdata         sp    cb    cg    sl  eg  er  exp_rdata     ebe   eaddr
    tbl[0]  = '{32'h0010_0040, 1'b0, 4'hF, 32'h0,        1,  1,  32'h1234_5678, 1'b0, 1'b0, 1'b0, 0,  2,  3,  32'h1234_5678, 1'b0, 32'h0};
    tbl[1]  = '{32'h0020_0004, 1'b1, 4'h3, 32'hCAFE_0001, 0, 0,  32'h0,        1'b0, 1'b0, 1'b0, 1,  1,  2,  32'h0,        1'b0, 32'h0};
    tbl[2]  = '{32'h0500_0000, 1'b0, 4'hF, 32'h0,        0,  1,  32'h0,        1'b0, 1'b0, 1'b0, -1, 1,  2,  32'hDEAD_BEEF, 1'b1, 32'h0500_0000};
    tbl[3]  = '{32'h0600_0000, 1'b0, 4'hF, 32'h0,        0,  1,  32'h0,        1'b0, 1'b0, 1'b0, -1, 1,  2,  32'hDEAD_BEEF, 1'b1, 32'h0500_0000};
    tbl[4]  = '{32'h0030_0000, 1'b0, 4'hF, 32'h0,        99, 1,  32'h0,        1'b0, 1'b1, 1'b0, 2,  16, 17, 32'hDEAD_BEEF, 1'b1, 32'h0030_0000};
    tbl[5]  = '{32'h0030_0010, 1'b0, 4'hF, 32'h0,        0,  99, 32'h0,        1'b0, 1'b0, 1'b0, 2,  1,  17, 32'hDEAD_BEEF, 1'b1, 32'h0030_0000};
    tbl[6]  = '{32'h0010_0000, 1'b0, 4'hF, 32'h0,        1,  3,  32'h2222_2222, 1'b1, 1'b0, 1'b0, 0,  2,  5,  32'h2222_2222, 1'b1, 32'h0030_0000};
    tbl[7]  = '{32'h0020_FFFC, 1'b0, 4'hF, 32'h0,        14, 15, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0, 1,  15, 30, 32'h0BAD_F00D, 1'b0, 32'h0};
    tbl[8]  = '{32'h0030_1234, 1'b1, 4'hC, 32'h5A5A_0000, 15, 1, 32'h0,        1'b0, 1'b0, 1'b0, 2,  16, 17, 32'hDEAD_BEEF, 1'b1, 32'h0030_1234};
    tbl[9]  = '{32'h0010_2000, 1'b0, 4'hF, 32'h0,        0,  1,  32'h0,        1'b0, 1'b0, 1'b0, -1, 1,  2,  32'hDEAD_BEEF, 1'b1, 32'h0030_1234};
    tbl[10] = '{32'h0010_1FFC, 1'b0, 4'hF, 32'h0,        1,  1,  32'hA5A5_5A5A, 1'b0, 1'b0, 1'b0, 0,  2,  3,  32'hA5A5_5A5A, 1'b1, 32'h0030_1234};
    tbl[11] = '{32'h0700_0000, 1'b0, 4'hF, 32'h0,        0,  1,  32'h0,        1'b0, 1'b0, 1'b1, -1, 1,  2,  32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[12] = '{32'h0800_0000, 1'b1, 4'h1, 32'h0000_00FF, 0, 1,  32'h0,        1'b0, 1'b0, 1'b0, -1, 1,  2,  32'hDEAD_BEEF, 1'b1, 32'h0800_0000};
    tbl[13] = '{32'h0020_0100, 1'b0, 4'hF, 32'h0,        0,  16, 32'h0,        1'b0, 1'b0, 1'b0, 1,  1,  17, 32'hDEAD_BEEF, 1'b1, 32'h0800_0000};

    rst_ni = 1'b0; m_req_i = 1'b0; m_we_i = 1'b0; err_clr_i = 1'b0;
    m_addr_i = 32'h0; m_wdata_i = 32'h0; m_be_i = 4'h0;
    s_gnt_i = '0; s_rvalid_i = '0; s_rdata_i = '0;
    #2;
    chk("reset outputs", {m_gnt_o, m_rvalid_o, s_req_o, m_rdata_o, bus_err_o, err_addr_o}, 72'h0);
    #20 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 14; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    be_m = 1'b1; ea_m = 32'h0800_0000;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: rv.addr = 32'h0010_0000 | ($urandom & 32'h0000_1FFC);
        1: rv.addr = 32'h0020_0000 | ($urandom & 32'h0000_FFFC);
        2: rv.addr = 32'h0030_0000 | ($urandom & 32'h0000_FFFC);
        3: rv.addr = 32'h0010_2000 + ($urandom & 32'h0000_DFFC);
        default: rv.addr = 32'h0040_0000 + ($urandom & 32'h0FFF_FFFC);
      endcase
      rv.we      = $urandom_range(0, 1);
      rv.be      = 4'($urandom);
      rv.wdata   = $urandom;
      rv.gnt_dly = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 3);
      rv.rv_dly  = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 17) : $urandom_range(1, 3);
      rv.rdata   = $urandom;
      rv.spur    = $urandom_range(0, 1);
      rv.clr_before = ($urandom_range(0, 7) == 0);
      rv.clr_at_gnt = 1'b0;
      predict(rv);
      run_txn(rv, $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
    end

    // Reset asserted mid-read with a new core request pending
    rv = '{32'h0900_0000, 1'b0, 4'hF, 32'h0, 0, 1, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 32'h0, 1'b0, 32'h0};
    predict(rv);
    run_txn(rv, "pre_rst");
    m_addr_i = 32'h0010_0100; m_we_i = 1'b0; m_req_i = 1'b1; s_gnt_i = 3'b001;
    @(negedge clk_i);
    chk("rst_seq gnt", {m_gnt_o, s_req_o}, {1'b1, 3'b001});
    @(posedge clk_i); #1;
    m_addr_i = 32'h0010_0200; m_req_i = 1'b1; s_gnt_i = 3'b001; s_rvalid_i = 3'b001;
    s_rdata_i[31:0] = 32'h5555_AAAA;
    #1 rst_ni = 1'b0;
    #1;
    chk("rst async outputs", {m_gnt_o, m_rvalid_o, s_req_o, m_rdata_o, bus_err_o, err_addr_o}, 72'h0);
    @(negedge clk_i);
    chk("rst held outputs", {m_gnt_o, m_rvalid_o, s_req_o, m_rdata_o, bus_err_o, err_addr_o}, 72'h0);
    @(posedge clk_i); #3;
    m_req_i = 1'b0; s_gnt_i = '0; s_rvalid_i = '0;
    rst_ni = 1'b1;
    be_m = 1'b0; ea_m = 32'h0;
    @(posedge clk_i); #1;
    rv = '{32'h0010_0080, 1'b0, 4'hF, 32'h0, 1, 2, 32'h7777_0001, 1'b0, 1'b0, 1'b0, 0, 0, 0, 32'h0, 1'b0, 32'h0};
    predict(rv);
    run_txn(rv, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
